// File: rtl/rx_prbs_ber_checker.sv
// rx_prbs_ber_checker: PRBS9 bit/error counter with per-channel lock on 4x oversampled I/Q
module rx_prbs_ber_chan #(
   parameter int NB_COUNT   = 32,
   parameter int ERR_THRESH = 64
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_clear,
   input  logic                i_dec,
   input  logic                i_bit,
   output logic                o_lock,
   output logic [NB_COUNT-1:0] o_bit_count,
   output logic [NB_COUNT-1:0] o_err_count
);
   typedef enum logic {SEED, CHECK} state_t;
   localparam logic [9:0] THR = 10'(ERR_THRESH);
   state_t state, state_n;
   logic [8:0] lfsr, lfsr_n, win, win_n;
   logic [9:0] werr, werr_n, tot;
   logic [NB_COUNT-1:0] bc_n, ec_n;
   logic lock_n, pred, err, wend, fail;
   assign pred = lfsr[8] ^ lfsr[4];
   assign err  = pred ^ i_bit;
   assign wend = win == 9'd510;
   assign tot  = werr + {9'd0, err};
   assign fail = tot > THR;
   // win doubles as the seed-bit counter while in SEED
   always_comb begin
      state_n = state;
      lfsr_n  = lfsr;
      win_n   = win;
      werr_n  = werr;
      lock_n  = o_lock;
      bc_n    = o_bit_count;
      ec_n    = o_err_count;
      if (i_dec && state == SEED) begin
         lfsr_n  = {lfsr[7:0], i_bit};
         win_n   = win == 9'd8 ? '0 : win + 9'd1;
         state_n = win == 9'd8 ? CHECK : SEED;
      end else if (i_dec) begin
         lfsr_n  = {lfsr[7:0], pred};
         bc_n    = o_bit_count + NB_COUNT'(~&o_bit_count);
         ec_n    = o_err_count + NB_COUNT'(err & ~&o_err_count);
         win_n   = wend ? '0 : win + 9'd1;
         werr_n  = wend ? '0 : tot;
         lock_n  = wend ? ~fail : o_lock;
         state_n = wend && fail ? SEED : CHECK;
      end
      if (i_clear) begin
         bc_n = '0;
         ec_n = '0;
      end
   end
   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         state       <= SEED;
         lfsr        <= '0;
         win         <= '0;
         werr        <= '0;
         o_lock      <= 1'b0;
         o_bit_count <= '0;
         o_err_count <= '0;
      end else begin
         state       <= state_n;
         lfsr        <= lfsr_n;
         win         <= win_n;
         werr        <= werr_n;
         o_lock      <= lock_n;
         o_bit_count <= bc_n;
         o_err_count <= ec_n;
      end
   end
endmodule

module rx_prbs_ber_checker #(
   parameter int NB_INPUT   = 8,
   parameter int NB_COUNT   = 32,
   parameter int ERR_THRESH = 64
) (
   input  logic                       clock,
   input  logic                       i_reset,
   input  logic                       i_enable,
   input  logic                       i_clear,
   input  logic [1:0]                 i_phase,
   input  logic signed [NB_INPUT-1:0] i_symbI,
   input  logic signed [NB_INPUT-1:0] i_symbQ,
   output logic                       o_lockI,
   output logic                       o_lockQ,
   output logic [NB_COUNT-1:0]        o_bit_countI,
   output logic [NB_COUNT-1:0]        o_bit_countQ,
   output logic [NB_COUNT-1:0]        o_err_countI,
   output logic [NB_COUNT-1:0]        o_err_countQ,
   output logic                       o_dec_valid
);
   logic [1:0] pc;
   logic signed [NB_INPUT-1:0] s_i, s_q;
   logic dv, hit;
   assign hit = pc == i_phase;
   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         pc  <= '0;
         dv  <= 1'b0;
         s_i <= '0;
         s_q <= '0;
      end else if (i_enable) begin
         pc <= pc + 2'd1;
         dv <= hit;
         if (hit) begin
            s_i <= i_symbI;
            s_q <= i_symbQ;
         end
      end
   end
   // a pending decision stays pending across a pause and is consumed on resume
   assign o_dec_valid = dv & i_enable;
   rx_prbs_ber_chan #(.NB_COUNT(NB_COUNT), .ERR_THRESH(ERR_THRESH)) u_chan_i (
      .clock(clock), .i_reset(i_reset), .i_clear(i_clear), .i_dec(o_dec_valid),
      .i_bit(s_i[NB_INPUT-1]), .o_lock(o_lockI), .o_bit_count(o_bit_countI), .o_err_count(o_err_countI)
   );
   rx_prbs_ber_chan #(.NB_COUNT(NB_COUNT), .ERR_THRESH(ERR_THRESH)) u_chan_q (
      .clock(clock), .i_reset(i_reset), .i_clear(i_clear), .i_dec(o_dec_valid),
      .i_bit(s_q[NB_INPUT-1]), .o_lock(o_lockQ), .o_bit_count(o_bit_countQ), .o_err_count(o_err_countQ)
   );
endmodule

// File: tb/tb_rx_prbs_ber_checker.sv
// tb_rx_prbs_ber_checker: randomized PRBS9 I/Q stimulus against a sequence-level reference model
module tb_rx_prbs_ber_checker;
   localparam int NBI = 8, NBC = 32, THR = 64, N = 8192;
   logic clock = 1'b0, i_reset = 1'b1, i_enable = 1'b0, i_clear = 1'b0;
   logic [1:0] i_phase = 2'd1;
   logic signed [NBI-1:0] i_symbI = '0, i_symbQ = '0;
   logic o_lockI, o_lockQ, o_dec_valid, s_lockI, s_lockQ, s_dec_valid;
   logic [NBC-1:0] o_bit_countI, o_bit_countQ, o_err_countI, o_err_countQ;
   logic [3:0] s_bcI, s_bcQ, s_ecI, s_ecQ;
   always #5 clock = ~clock;

   rx_prbs_ber_checker #(.NB_INPUT(NBI), .NB_COUNT(NBC), .ERR_THRESH(THR)) dut (
      .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_clear), .i_phase(i_phase),
      .i_symbI(i_symbI), .i_symbQ(i_symbQ), .o_lockI(o_lockI), .o_lockQ(o_lockQ),
      .o_bit_countI(o_bit_countI), .o_bit_countQ(o_bit_countQ),
      .o_err_countI(o_err_countI), .o_err_countQ(o_err_countQ), .o_dec_valid(o_dec_valid)
   );
   rx_prbs_ber_checker #(.NB_INPUT(NBI), .NB_COUNT(4), .ERR_THRESH(THR)) dut_s (
      .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_clear(i_clear), .i_phase(i_phase),
      .i_symbI(i_symbI), .i_symbQ(i_symbQ), .o_lockI(s_lockI), .o_lockQ(s_lockQ),
      .o_bit_countI(s_bcI), .o_bit_countQ(s_bcQ),
      .o_err_countI(s_ecI), .o_err_countQ(s_ecQ), .o_dec_valid(s_dec_valid)
   );

   int total = 0, bad = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   // transmitted PRBS9 sequences and stimulus controls
   bit txi[N], txq[N];
   int tx, flip_k = -1;
   bit inv_i, clean;
   // reference model: phase/decision tracking and per-channel expected sequence
   int m_pc, m_ndec;
   bit m_dv, m_dI, m_dQ;
   int m_bc[2], m_ec[2], m_win[2], m_werr[2], rn[2];
   bit m_check[2], m_lock[2];
   bit rs[2][N];

   function automatic bit pred(input int c);
      return rs[c][rn[c]-9] ^ rs[c][rn[c]-5];
   endfunction

   task automatic model_reset();
      m_pc = 0; m_dv = 0; m_ndec = 0; tx = 0;
      for (int c = 0; c < 2; c++) begin
         m_bc[c] = 0; m_ec[c] = 0; m_win[c] = 0; m_werr[c] = 0; rn[c] = 0;
         m_check[c] = 0; m_lock[c] = 0;
      end
   endtask

   task automatic chan_step(input int c, input bit d);
      bit e;
      if (!m_check[c]) begin
         rs[c][rn[c]] = d;
         rn[c]++;
         if (rn[c] == 9) begin
            m_check[c] = 1; m_win[c] = 0; m_werr[c] = 0;
         end
      end else begin
         e = pred(c);
         rs[c][rn[c]] = e;
         rn[c]++;
         m_bc[c]++;
         if (e != d) begin
            m_ec[c]++;
            m_werr[c]++;
         end
         m_win[c]++;
         if (m_win[c] == 511) begin
            m_lock[c] = m_werr[c] <= THR;
            if (m_werr[c] > THR) begin
               m_check[c] = 0;
               rn[c] = 0;
            end
            m_win[c] = 0;
            m_werr[c] = 0;
         end
      end
   endtask

   task automatic tick();
      int k, mi, mq;
      bit bi, bq;
      k = tx / 4;
      bi = txi[k % N] ^ inv_i ^ (k == flip_k);
      bq = txq[k % N];
      mi = clean ? 64 : int'($urandom_range(1, 127));
      mq = clean ? 64 : int'($urandom_range(1, 127));
      i_symbI = NBI'(bi ? -mi : mi);
      i_symbQ = NBI'(bq ? -mq : mq);
      if (i_enable) begin
         if (m_dv) begin
            chan_step(0, m_dI);
            chan_step(1, m_dQ);
            m_ndec++;
         end
         m_dv = m_pc == int'(i_phase);
         if (m_dv) begin
            m_dI = bi; m_dQ = bq;
         end
         m_pc = (m_pc + 1) % 4;
         tx++;
      end
      if (i_clear)
         for (int c = 0; c < 2; c++) begin
            m_bc[c] = 0; m_ec[c] = 0;
         end
      @(posedge clock);
      @(negedge clock);
      chk("dec_valid", o_dec_valid, m_dv & i_enable);
      chk("lockI", o_lockI, m_lock[0]);
      chk("lockQ", o_lockQ, m_lock[1]);
      chk("bitI", o_bit_countI, m_bc[0]);
      chk("bitQ", o_bit_countQ, m_bc[1]);
      chk("errI", o_err_countI, m_ec[0]);
      chk("errQ", o_err_countQ, m_ec[1]);
      chk("sat_bitI", s_bcI, m_bc[0] > 15 ? 15 : m_bc[0]);
      chk("sat_errI", s_ecI, m_ec[0] > 15 ? 15 : m_ec[0]);
   endtask

   task automatic run_ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic run_until_dec(input int n);
      int g = 0;
      while (m_ndec < n && g < 20000) begin
         tick();
         g++;
      end
      chk("dec_reach", m_ndec, n);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_dv"}, o_dec_valid, 0);
      chk({tag, "_lockI"}, o_lockI, 0);
      chk({tag, "_lockQ"}, o_lockQ, 0);
      chk({tag, "_bitI"}, o_bit_countI, 0);
      chk({tag, "_bitQ"}, o_bit_countQ, 0);
      chk({tag, "_errI"}, o_err_countI, 0);
      chk({tag, "_errQ"}, o_err_countQ, 0);
   endtask

   initial begin
      #2_000_000;
      chk("watchdog", 1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int si, sq, g, held_b;
      bit found;
      si = $urandom_range(1, 511);
      sq = $urandom_range(1, 511);
      for (int n = 0; n < N; n++) begin
         txi[n] = n < 9 ? si[n] : txi[n-9] ^ txi[n-5];
         txq[n] = n < 9 ? sq[n] : txq[n-9] ^ txq[n-5];
      end
      model_reset();
      clean = 1; inv_i = 0; i_phase = 2'd1; i_enable = 1'b1;
      repeat (2) @(negedge clock);
      check_all_zero("reset");
      i_reset = 1'b0;

      run_until_dec(519);
      chk("lockI_519", o_lockI, 0);
      chk("bitI_519", o_bit_countI, 510);
      run_until_dec(520);
      chk("lockI_520", o_lockI, 1);
      chk("lockQ_520", o_lockQ, 1);
      chk("bitI_520", o_bit_countI, 511);
      chk("bitQ_520", o_bit_countQ, 511);
      chk("errI_520", o_err_countI, 0);
      chk("errQ_520", o_err_countQ, 0);

      clean = 0;
      run_ticks(200);
      flip_k = tx / 4 + 2;
      run_ticks(40);
      chk("flip_errI", o_err_countI, 1);
      chk("flip_errQ", o_err_countQ, 0);
      chk("flip_lockI", o_lockI, 1);

      flip_k = tx / 4 + 3;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (m_dv && m_check[0] && m_dI != pred(0)) begin
            i_clear = 1'b1;
            tick();
            i_clear = 1'b0;
            found = 1;
         end else tick();
      end
      flip_k = -1;
      chk("clr_hit", found, 1);
      chk("clr_bitI", o_bit_countI, 0);
      chk("clr_bitQ", o_bit_countQ, 0);
      chk("clr_errI", o_err_countI, 0);
      chk("clr_errQ", o_err_countQ, 0);
      chk("clr_lockI", o_lockI, 1);
      chk("clr_lockQ", o_lockQ, 1);

      run_ticks(50);
      held_b = m_bc[0];
      i_enable = 1'b0;
      run_ticks(10);
      chk("pause_bitI", o_bit_countI, held_b);
      i_enable = 1'b1;
      run_ticks(400);
      chk("resume_errI", o_err_countI, 0);
      chk("resume_errQ", o_err_countQ, 0);
      chk("resume_lockI", o_lockI, 1);

      inv_i = 1;
      g = 0;
      while (m_lock[0] && g < 5000) begin
         tick();
         g++;
      end
      chk("inv_fall_seen", m_lock[0], 0);
      chk("inv_lockI", o_lockI, 0);
      chk("inv_lockQ", o_lockQ, 1);
      chk("inv_errQ", o_err_countQ, 0);
      held_b = m_bc[0];
      run_ticks(20);
      chk("inv_held_bitI", o_bit_countI, held_b);
      inv_i = 0;

      repeat (6) begin
         i_phase = 2'($urandom_range(0, 3));
         repeat ($urandom_range(300, 900)) begin
            i_enable = $urandom_range(0, 19) != 0;
            i_clear = $urandom_range(0, 199) == 0;
            tick();
         end
      end
      i_enable = 1'b1;
      i_clear = 1'b0;

      i_phase = 2'd1;
      g = 0;
      while (!(m_lock[0] && m_lock[1] && m_bc[0] > 0) && g < 10000) begin
         tick();
         g++;
      end
      chk("relock_seen", m_lock[0] & m_lock[1], 1);
      #2 i_reset = 1'b1;
      #1 check_all_zero("async_rst");
      @(negedge clock);
      i_reset = 1'b0;
      model_reset();
      i_phase = 2'd2;
      run_ticks(2);
      chk("post_rst_dv0", o_dec_valid, 0);
      run_ticks(1);
      chk("post_rst_dv1", o_dec_valid, 1);
      run_until_dec(520);
      chk("post_rst_lockI", o_lockI, 1);
      chk("post_rst_bitQ", o_bit_countQ, 511);
      chk("post_rst_sat_bitI", s_bcI, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rx_prbs_ber_checker.md
RX_PRBS_BER_CHECKER -- requirements
Module: rx_prbs_ber_checker

Interface
REQ-001 SHALL have parameter NB_INPUT, default 8, meaning signed sample width of the I/Q inputs.
REQ-002 SHALL have parameter NB_COUNT, default 32, meaning width of each bit and error counter.
REQ-003 SHALL have parameter ERR_THRESH, default 64, meaning the maximum number of errors per 511-bit window that keeps lock.
REQ-004 SHALL have port clock, input, 1, the single system clock.
REQ-005 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_enable, input, 1, which freezes all state when low.
REQ-007 SHALL have port i_clear, input, 1, a synchronous clear of the bit and error counters.
REQ-008 SHALL have port i_phase, input, 2, the sampling phase within the 4-sample symbol period.
REQ-009 SHALL have ports i_symbI and i_symbQ, input, NB_INPUT signed, the oversampled TX filter outputs (4 samples per symbol).
REQ-010 SHALL have ports o_lockI and o_lockQ, output, 1, the per-channel lock flags.
REQ-011 SHALL have ports o_bit_countI and o_bit_countQ, output, NB_COUNT, the compared bits per channel.
REQ-012 SHALL have ports o_err_countI and o_err_countQ, output, NB_COUNT, the bit errors per channel.
REQ-013 SHALL have port o_dec_valid, output, 1, a one-cycle strobe per decision.

Function
REQ-014 SHALL run a 2-bit phase counter 0,1,2,3,0,... that advances each enabled clock.
REQ-015 SHALL register i_symbI and i_symbQ in the cycle where phase counter == i_phase; this is the sample cycle.
REQ-016 SHALL assert o_dec_valid for exactly the cycle after each sample cycle, with decision bit = sign bit of the registered sample (negative -> 1, non-negative -> 0).
REQ-017 SHALL apply an i_phase change at the next comparison, without forcing resync.
REQ-018 SHALL run two independent identical channel checkers (I, Q), each with a local PRBS9 LFSR, polynomial x^9+x^5+1.
REQ-019 SHALL give each channel an FSM with states SEED and CHECK, with reset state SEED.
REQ-020 SEED SHALL shift 9 consecutive decisions into the local LFSR, then go to CHECK; SEED decisions SHALL NOT be counted.
REQ-021 CHECK SHALL, per decision, advance the LFSR one step and compare its output bit with the decision; a mismatch is an error.
REQ-022 In CHECK, bit_count SHALL increment by 1 per decision, and err_count by 1 per error, both visible 2 cycles after the sample cycle.
REQ-023 SHALL make counters saturate at all-ones, never wrapping.
REQ-024 CHECK SHALL keep a window counter 0..510 and a window error count; at window end, if errors > ERR_THRESH, the channel SHALL clear lock and go to SEED, else set lock and stay in CHECK; the window error count SHALL restart at 0 in either case.
REQ-025 SHALL keep bit_count and err_count unchanged when lock is lost.
REQ-026 i_clear high SHALL zero all four counters on the next edge; lock, FSM and window state SHALL be unaffected; i_clear SHALL win over a simultaneous increment.
REQ-027 i_enable low SHALL hold the phase counter, FSM, LFSR, window and counters, and force o_dec_valid low; i_clear SHALL still act.

Reset
REQ-028 i_reset high SHALL immediately, independent of clock, force all counters, lock flags, o_dec_valid, phase counter, window counters and LFSRs to 0 and both FSMs to SEED.
REQ-029 After i_reset deasserts, the first sample cycle SHALL occur when the phase counter first equals i_phase.

Verification
REQ-030 The bench SHALL cover: reset asserted mid-CHECK -> all outputs 0 in the same cycle, no clock edge needed.
REQ-031 The bench SHALL cover: clean PRBS9 on I/Q, amplitude +/-64, 4 samples/symbol, i_phase=1 -> lock after decision 520 (9 seed + 511), err counts 0, bit counts = decisions - 9.
REQ-032 The bench SHALL cover: locked, one I symbol inverted -> o_err_countI +1, o_err_countQ unchanged, o_lockI stays 1.
REQ-033 The bench SHALL cover: I input replaced by an all-inverted PRBS -> window errors 511 > 64 -> o_lockI falls at window end, I FSM in SEED, counters held; Q unaffected.
REQ-034 The bench SHALL cover: i_clear pulse coincident with an error decision -> all counters 0 next cycle, lock unchanged.
REQ-035 The bench SHALL cover: i_enable low for 10 cycles mid-CHECK -> no counter change, no o_dec_valid; on resume, counting continues with 0 added errors.
